// File: rtl/msx_io_device_table_if.sv
// Configuration stream, CPU I/O bus and device-select bundle for the I/O device table.
interface msx_io_device_table_if #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ID_W        = 4
);
  // configuration stream
  logic                   cfg_start;
  logic                   cfg_wr;
  logic [7:0]             cfg_data;
  logic                   cfg_last;
  logic                   cfg_ready;
  logic                   cfg_error;
  // CPU I/O bus
  logic                   iorq;
  logic                   m1;
  logic                   rd;
  logic                   wr;
  logic [7:0]             addr;
  // device select
  logic [NUM_ENTRIES-1:0] dev_hit;
  logic                   dev_en;
  logic                   dev_we;
  logic [ID_W-1:0]        dev_id;
  logic [1:0]             dev_num;
  logic [7:0]             dev_param;

  modport master (
    output cfg_start, cfg_wr, cfg_data, cfg_last,
    input  cfg_ready, cfg_error,
    output iorq, m1, rd, wr, addr,
    input  dev_hit, dev_en, dev_we, dev_id, dev_num, dev_param
  );

  modport slave (
    input  cfg_start, cfg_wr, cfg_data, cfg_last,
    output cfg_ready, cfg_error,
    input  iorq, m1, rd, wr, addr,
    output dev_hit, dev_en, dev_we, dev_id, dev_num, dev_param
  );
endinterface

// File: rtl/msx_io_device_table.sv
// Run-time loadable, priority-ordered I/O port decoder. Entries are loaded from a
// byte stream (mask, port, num, param, id) and every qualified Z80 I/O cycle is
// matched against the table, producing a registered device select.
module msx_io_device_table #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ID_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  msx_io_device_table_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_ENTRIES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q;
  logic [2:0]             idx_q;
  logic                   err_q;
  logic [7:0]             mask_a, port_a, param_a;
  logic [1:0]             num_a;

  logic [7:0]             mask_q  [NUM_ENTRIES];
  logic [7:0]             port_q  [NUM_ENTRIES];
  logic [1:0]             num_q   [NUM_ENTRIES];
  logic [7:0]             param_q [NUM_ENTRIES];
  logic [ID_W-1:0]        id_q    [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;

  logic                   found;
  logic [NUM_ENTRIES-1:0] win_oh;
  logic [ID_W-1:0]        win_id;
  logic [1:0]             win_num;
  logic [7:0]             win_param;
  logic                   acc, acc_q, start;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; cfg_start takes precedence over any stream byte
  always_comb begin
    state_d = state_q;
    if (bus.cfg_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (bus.cfg_wr && bus.cfg_last) state_d = READY;
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.cfg_ready = (state_q == READY);
  assign bus.cfg_error = err_q;

  // Stream assembly and table write; bytes past a full table are dropped
  always_ff @(posedge clk) begin
    if (reset || bus.cfg_start) begin
      valid_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else if (state_q == LOAD && bus.cfg_wr) begin
      if (count_q == CW'(NUM_ENTRIES)) begin
        err_q <= 1'b1;
      end else begin
        case (idx_q)
          3'd0: mask_a  <= bus.cfg_data;
          3'd1: port_a  <= bus.cfg_data;
          3'd2: num_a   <= bus.cfg_data[1:0];
          3'd3: param_a <= bus.cfg_data;
          default: begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
              if (count_q == CW'(i)) begin
                mask_q[i]  <= mask_a;
                port_q[i]  <= port_a;
                num_q[i]   <= num_a;
                param_q[i] <= param_a;
                id_q[i]    <= bus.cfg_data[ID_W-1:0];
                valid_q[i] <= 1'b1;
              end
            end
            count_q <= count_q + CW'(1);
          end
        endcase
        idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end
      if (bus.cfg_last) begin
        if (idx_q != 3'd4) err_q <= 1'b1;
        idx_q <= '0;
      end
    end
  end

  // Priority match: the lowest-index valid entry covering addr wins
  always_comb begin
    found     = 1'b0;
    win_oh    = '0;
    win_id    = '0;
    win_num   = '0;
    win_param = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!found && valid_q[i] && (((bus.addr ^ port_q[i]) & mask_q[i]) == 8'h00)) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_id    = id_q[i];
        win_num   = num_q[i];
        win_param = param_q[i];
      end
    end
  end

  assign acc   = bus.iorq && !bus.m1 && (bus.rd || bus.wr) && bus.cfg_ready;
  assign start = clk_en && acc && !acc_q;

  // Latch the winner at access start and hold it until the access ends
  always_ff @(posedge clk) begin
    if (reset || bus.cfg_start) begin
      acc_q         <= 1'b0;
      bus.dev_hit   <= '0;
      bus.dev_en    <= 1'b0;
      bus.dev_we    <= 1'b0;
      bus.dev_id    <= '0;
      bus.dev_num   <= '0;
      bus.dev_param <= '0;
    end else begin
      if (clk_en) acc_q <= acc;
      bus.dev_en <= 1'b0;
      if (start) begin
        bus.dev_hit   <= win_oh;
        bus.dev_en    <= found;
        bus.dev_we    <= bus.wr;
        bus.dev_id    <= win_id;
        bus.dev_num   <= win_num;
        bus.dev_param <= win_param;
      end else if (!acc) begin
        bus.dev_hit   <= '0;
        bus.dev_we    <= 1'b0;
        bus.dev_id    <= '0;
        bus.dev_num   <= '0;
        bus.dev_param <= '0;
      end
    end
  end
endmodule

// File: tb/tb_msx_io_device_table.sv
// Directed bench for the I/O device table decoder.
module tb_msx_io_device_table;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  int   checks   = 0;
  int   failures = 0;

  msx_io_device_table_if #(.NUM_ENTRIES(N), .ID_W(IW)) bus ();

  msx_io_device_table #(.NUM_ENTRIES(N), .ID_W(IW)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_byte(input logic [7:0] b, input logic last);
    bus.cfg_wr   = 1'b1;
    bus.cfg_data = b;
    bus.cfg_last = last;
    tick();
    bus.cfg_wr   = 1'b0;
    bus.cfg_last = 1'b0;
  endtask

  task automatic cfg_entry(input logic [7:0] m, input logic [7:0] p, input logic [7:0] n,
                           input logic [7:0] pr, input logic [7:0] id, input logic last);
    cfg_byte(m, 1'b0);
    cfg_byte(p, 1'b0);
    cfg_byte(n, 1'b0);
    cfg_byte(pr, 1'b0);
    cfg_byte(id, last);
  endtask

  task automatic cfg_begin();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic bus_start(input logic r, input logic w, input logic m, input logic [7:0] a);
    bus.iorq = 1'b1;
    bus.rd   = r;
    bus.wr   = w;
    bus.m1   = m;
    bus.addr = a;
    tick();
  endtask

  task automatic bus_end();
    bus.iorq = 1'b0;
    bus.rd   = 1'b0;
    bus.wr   = 1'b0;
    bus.m1   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.cfg_ready !== 1'b0 || bus.cfg_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_cfg: ready=%b error=%b required 0 0", bus.cfg_ready, bus.cfg_error);
    end
    checks++;
    if (bus.dev_hit !== 8'h00 || bus.dev_en !== 1'b0 || bus.dev_id !== 4'h0) begin
      failures++;
      $display("FAIL reset_dev: hit=%h en=%b id=%h required 00 0 0", bus.dev_hit, bus.dev_en, bus.dev_id);
    end
  endtask

  task automatic test_early_access();
    cfg_begin();
    bus_start(1'b1, 1'b0, 1'b0, 8'h98);
    checks++;
    if (bus.dev_en !== 1'b0 || bus.dev_hit !== 8'h00) begin
      failures++;
      $display("FAIL not_ready_access: en=%b hit=%h required 0 00", bus.dev_en, bus.dev_hit);
    end
    bus_end();
  endtask

  task automatic test_load();
    cfg_begin();
    cfg_entry(8'hFF, 8'h98, 8'h00, 8'h00, 8'h03, 1'b0);
    cfg_entry(8'hFE, 8'h7C, 8'h01, 8'h05, 8'h01, 1'b1);
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.cfg_error !== 1'b0) begin
      failures++;
      $display("FAIL load_two: ready=%b error=%b required 1 0", bus.cfg_ready, bus.cfg_error);
    end
  endtask

  task automatic test_write_access();
    bus_start(1'b0, 1'b1, 1'b0, 8'h7D);
    checks++;
    if (bus.dev_hit !== 8'h02 || bus.dev_id !== 4'h1 || bus.dev_num !== 2'd1 ||
        bus.dev_param !== 8'h05 || bus.dev_we !== 1'b1 || bus.dev_en !== 1'b1) begin
      failures++;
      $display("FAIL out_7d: hit=%h id=%h num=%0d param=%h we=%b en=%b required 02 1 1 05 1 1",
               bus.dev_hit, bus.dev_id, bus.dev_num, bus.dev_param, bus.dev_we, bus.dev_en);
    end
    tick();
    checks++;
    if (bus.dev_en !== 1'b0 || bus.dev_hit !== 8'h02 || bus.dev_id !== 4'h1) begin
      failures++;
      $display("FAIL out_7d_hold: en=%b hit=%h id=%h required 0 02 1", bus.dev_en, bus.dev_hit, bus.dev_id);
    end
    bus_end();
    checks++;
    if (bus.dev_hit !== 8'h00 || bus.dev_id !== 4'h0 || bus.dev_param !== 8'h00 || bus.dev_we !== 1'b0) begin
      failures++;
      $display("FAIL out_7d_release: hit=%h id=%h param=%h we=%b required 00 0 00 0",
               bus.dev_hit, bus.dev_id, bus.dev_param, bus.dev_we);
    end
  endtask

  task automatic test_miss_and_m1();
    bus_start(1'b1, 1'b0, 1'b0, 8'h99);
    checks++;
    if (bus.dev_id !== 4'h0 || bus.dev_hit !== 8'h00 || bus.dev_en !== 1'b0) begin
      failures++;
      $display("FAIL miss_99: id=%h hit=%h en=%b required 0 00 0", bus.dev_id, bus.dev_hit, bus.dev_en);
    end
    bus_end();
    bus_start(1'b1, 1'b0, 1'b0, 8'h7E);
    checks++;
    if (bus.dev_hit !== 8'h00 || bus.dev_en !== 1'b0) begin
      failures++;
      $display("FAIL miss_7e_mask: hit=%h en=%b required 00 0", bus.dev_hit, bus.dev_en);
    end
    bus_end();
    bus_start(1'b1, 1'b0, 1'b1, 8'h98);
    checks++;
    if (bus.dev_en !== 1'b0 || bus.dev_hit !== 8'h00) begin
      failures++;
      $display("FAIL int_ack: en=%b hit=%h required 0 00", bus.dev_en, bus.dev_hit);
    end
    bus_end();
  endtask

  task automatic test_clk_en();
    clk_en = 1'b0;
    bus_start(1'b1, 1'b0, 1'b0, 8'h98);
    checks++;
    if (bus.dev_en !== 1'b0 || bus.dev_hit !== 8'h00) begin
      failures++;
      $display("FAIL clk_en_low: en=%b hit=%h required 0 00", bus.dev_en, bus.dev_hit);
    end
    clk_en = 1'b1;
    tick();
    checks++;
    if (bus.dev_en !== 1'b1 || bus.dev_hit !== 8'h01 || bus.dev_id !== 4'h3 || bus.dev_we !== 1'b0) begin
      failures++;
      $display("FAIL clk_en_high: en=%b hit=%h id=%h we=%b required 1 01 3 0",
               bus.dev_en, bus.dev_hit, bus.dev_id, bus.dev_we);
    end
    bus_end();
  endtask

  task automatic test_priority();
    cfg_begin();
    cfg_entry(8'h00, 8'h00, 8'h02, 8'hA5, 8'h02, 1'b0);
    cfg_entry(8'hFF, 8'h98, 8'h00, 8'h00, 8'h03, 1'b1);
    bus_start(1'b1, 1'b0, 1'b0, 8'h98);
    checks++;
    if (bus.dev_hit !== 8'h01 || bus.dev_id !== 4'h2 || bus.dev_num !== 2'd2 || bus.dev_param !== 8'hA5) begin
      failures++;
      $display("FAIL priority_98: hit=%h id=%h num=%0d param=%h required 01 2 2 a5",
               bus.dev_hit, bus.dev_id, bus.dev_num, bus.dev_param);
    end
    bus_end();
  endtask

  task automatic test_partial();
    cfg_begin();
    cfg_byte(8'hFF, 1'b0);
    cfg_byte(8'h98, 1'b0);
    cfg_byte(8'h00, 1'b0);
    cfg_byte(8'h00, 1'b1);
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.cfg_error !== 1'b1) begin
      failures++;
      $display("FAIL partial_entry: ready=%b error=%b required 1 1", bus.cfg_ready, bus.cfg_error);
    end
    bus_start(1'b1, 1'b0, 1'b0, 8'h98);
    checks++;
    if (bus.dev_hit !== 8'h00 || bus.dev_en !== 1'b0) begin
      failures++;
      $display("FAIL partial_dropped: hit=%h en=%b required 00 0", bus.dev_hit, bus.dev_en);
    end
    bus_end();
  endtask

  task automatic test_overflow_and_restart();
    cfg_begin();
    for (int unsigned i = 0; i < N; i++)
      cfg_entry(8'hFF, 8'h10 + 8'(i), 8'(i), 8'h20 + 8'(i), 8'(i + 1), 1'b0);
    checks++;
    if (bus.cfg_error !== 1'b0) begin
      failures++;
      $display("FAIL full_no_error: error=%b required 0", bus.cfg_error);
    end
    cfg_entry(8'hFF, 8'h40, 8'h00, 8'h00, 8'h09, 1'b1);
    checks++;
    if (bus.cfg_error !== 1'b1 || bus.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL overflow: error=%b ready=%b required 1 1", bus.cfg_error, bus.cfg_ready);
    end
    bus_start(1'b0, 1'b1, 1'b0, 8'h40);
    checks++;
    if (bus.dev_hit !== 8'h00 || bus.dev_id !== 4'h0) begin
      failures++;
      $display("FAIL overflow_unmatched: hit=%h id=%h required 00 0", bus.dev_hit, bus.dev_id);
    end
    bus_end();
    bus_start(1'b1, 1'b0, 1'b0, 8'h17);
    checks++;
    if (bus.dev_hit !== 8'h80 || bus.dev_id !== 4'h8 || bus.dev_num !== 2'd3 || bus.dev_param !== 8'h27) begin
      failures++;
      $display("FAIL last_slot: hit=%h id=%h num=%0d param=%h required 80 8 3 27",
               bus.dev_hit, bus.dev_id, bus.dev_num, bus.dev_param);
    end
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    checks++;
    if (bus.dev_hit !== 8'h00 || bus.dev_id !== 4'h0 || bus.dev_param !== 8'h00 ||
        bus.cfg_ready !== 1'b0 || bus.cfg_error !== 1'b0) begin
      failures++;
      $display("FAIL restart_mid_access: hit=%h id=%h param=%h ready=%b error=%b required 00 0 00 0 0",
               bus.dev_hit, bus.dev_id, bus.dev_param, bus.cfg_ready, bus.cfg_error);
    end
    bus_end();
  endtask

  initial begin
    reset         = 1'b1;
    clk_en        = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_wr    = 1'b0;
    bus.cfg_data  = 8'h00;
    bus.cfg_last  = 1'b0;
    bus.iorq      = 1'b0;
    bus.m1        = 1'b0;
    bus.rd        = 1'b0;
    bus.wr        = 1'b0;
    bus.addr      = 8'h00;
    test_reset();
    test_early_access();
    test_load();
    test_write_access();
    test_miss_and_m1();
    test_clk_en();
    test_priority();
    test_partial();
    test_overflow_and_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
